exe_muldiv_stage: RTL
=====================

// Module: exe_muldiv_stage
// PURPOSE
//  EXE-stage back end feeding MEM. Registers the EX/MEM pipeline fields and owns the HI/LO pair.
//  Runs an iterative multiply/divide unit for MULT/MULTU/DIV/DIVU.
//  Serves MFHI/MFLO/MTHI/MTLO and raises STALL_OUT to the hazard unit on HI/LO conflicts.
// PARAMETERS
//  BITS_PER_CYCLE  1   bits retired per iteration; legal 1,2,4; ITER = 32/BITS_PER_CYCLE
// PORTS
//  CLK                 in   1   clock
//  RESET               in   1   reset; synchronous, active-low
//  Instr1_IN/Instr1_PC_IN      in  32  instruction/PC (debug, passed through)
//  ALU_result1_IN      in   32  combinational ALU result
//  OperandA1_IN        in   32  rs value (forwarded)
//  OperandB1_IN        in   32  rt value (forwarded)
//  WriteRegister1_IN   in   5   destination register
//  MemWriteData1_IN    in   32  store data
//  RegWrite1_IN        in   1   register write request
//  ALU_Control1_IN     in   6   op code; 0 = NOP
//  MemRead1_IN/MemWrite1_IN    in  1   load/store request
//  Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT  out 32  EX/MEM register
//  WriteRegister1_OUT  out  5   EX/MEM register
//  ALU_Control1_OUT    out  6   EX/MEM register
//  RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT  out 1  EX/MEM register
//  STALL_OUT           out  1   combinational; upstream holds EXE inputs while high
//  MulDivBusy_OUT      out  1   registered; FSM not IDLE
// BEHAVIOUR
//  Reset (RESET==0 at posedge): all outputs 0; HI=LO=0; FSM IDLE; counter 0.
//   An in-flight mul/div is aborted and its result is discarded.
//  Ops:
//   MULT=6'b011000, MULTU=011001, DIV=011010, DIVU=011011.
//   MFHI=010000, MTHI=010001, MFLO=010010, MTLO=010011.
//  hilo_op = any of the eight ops above.
//  STALL_OUT = (state!=IDLE) & hilo_op(ALU_Control1_IN).
//  Stalled cycle: EX/MEM loads a bubble. Every field is 0, so MEM sees a NOP. HI/LO are untouched.
//  Non-stalled cycle: EX/MEM loads the *_IN fields. ALU_result1_OUT is set as follows:
//   MFHI -> HI; MFLO -> LO; otherwise ALU_result1_IN.
//   MULT*/DIV*/MT* are forced to RegWrite1_OUT=0.
//  MTHI/MTLO write HI/LO with OperandA1_IN at the same edge. MFHI in the next cycle reads the new value.
//  FSM IDLE -> MUL or DIV:
//   On a non-stalled MULT*/DIV*, latch the operands and set counter=ITER.
//   Unsigned ops use raw operands. Signed ops use magnitudes plus a recorded result sign.
//  MUL/DIV: each cycle retires BITS_PER_CYCLE bits (shift-add, restoring divide) and decrements the counter.
//   When counter==1, HI/LO are written at that edge and the next state is IDLE.
//  Stall length: a hilo_op arriving the cycle after issue stalls exactly ITER cycles. It proceeds in the cycle after HI/LO update.
//  Non-hilo instructions flow without stalls while busy. Loads and stores are unaffected.
//  Result rules:
//   MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
//   DIV: LO = quotient truncated toward 0; HI = remainder with the sign of the dividend.
//  Boundary cases:
//   Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=dividend.
//   DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
//   Multiplying the most negative value is exact in 64 bits.
//  Simultaneous events: reset wins over everything. A completing op and a new issue cannot coincide, because issue requires IDLE.
// STRUCTURE
//  Package muldiv_pkg: 6-bit op constants, FSM state enum {IDLE,MUL,DIV}, ITER localparam.
//  One sub-module, muldiv_iter: operands in, start, busy, done pulse, 64-bit result. It holds the FSM and datapath.
//   The top level keeps HI/LO, the stall logic and the EX/MEM register.
// TESTING
//  MULT 7 * -3, then MFLO next cycle, BITS_PER_CYCLE=1:
//   STALL_OUT high exactly 32 cycles; then MFLO yields 32'hFFFFFFEB and HI=32'hFFFFFFFF.
//  MULTU FFFFFFFF*FFFFFFFF followed by 5 ADDs:
//   no stall; the ADDs reach MEM unchanged; then HI=FFFFFFFE, LO=00000001.
//  DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 9/0 -> LO=FFFFFFFF, HI=9.
//   DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  MTHI 32'h1234 then MFHI next cycle:
//   no stall; ALU_result1_OUT=32'h1234; the MTHI slot has RegWrite1_OUT=0.
//  RESET low 1 cycle at iteration 10 of a DIV:
//   all outputs 0, HI=LO=0, MulDivBusy_OUT=0 after that edge; a following MFLO returns 0 unstalled.
//  Repeat tests 1-3 with BITS_PER_CYCLE=4: stall lasts 8 cycles; results are identical.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and helpers for the EXE-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  // Operand width; the iteration count is ITER / BITS_PER_CYCLE.
  localparam int ITER = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV} muldiv_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_wdata;
    logic [4:0]  write_reg;
    logic [5:0]  alu_ctrl;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  // MULT/MULTU/DIV/DIVU share 0110xx, MFHI/MTHI/MFLO/MTLO share 0100xx.
  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction

  function automatic logic is_hilo_op(input logic [5:0] op);
    return (op[5:2] == 4'b0110) || (op[5:2] == 4'b0100);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider retiring BITS_PER_CYCLE bits per cycle.
// done is a combinational pulse in the last iteration; result is valid alongside it.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  localparam int NUM_ITER = ITER / BITS_PER_CYCLE;
  localparam int CW       = $clog2(NUM_ITER + 1);

  muldiv_state_t state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   opnd_reg, opnd_next;
  logic [31:0]   dvd_reg, dvd_next;
  logic          neg_reg, neg_next;
  logic          rneg_reg, rneg_next;
  logic          dbz_reg, dbz_next;

  logic [31:0] a_mag, b_mag;
  logic [31:0] hi_c [BITS_PER_CYCLE+1];
  logic [31:0] lo_c [BITS_PER_CYCLE+1];
  logic [63:0] prod;

  assign a_mag = (is_signed && op_a[31]) ? -op_a : op_a;
  assign b_mag = (is_signed && op_b[31]) ? -op_b : op_b;

  // hi holds the partial product / remainder, lo the multiplier / dividend-quotient.
  assign hi_c[0] = hi_reg;
  assign lo_c[0] = lo_reg;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] sub_diff;

    assign add_sum  = {1'b0, hi_c[gi]} + (lo_c[gi][0] ? {1'b0, opnd_reg} : 33'd0);
    assign shifted  = {hi_c[gi], lo_c[gi][31]};
    assign sub_diff = shifted - {1'b0, opnd_reg};

    assign hi_c[gi+1] = (state_reg == DIV) ? (sub_diff[32] ? shifted[31:0] : sub_diff[31:0])
                                           : add_sum[32:1];
    assign lo_c[gi+1] = (state_reg == DIV) ? {lo_c[gi][30:0], ~sub_diff[32]}
                                           : {add_sum[0], lo_c[gi][31:1]};
  end

  assign prod = {hi_c[BITS_PER_CYCLE], lo_c[BITS_PER_CYCLE]};
  assign busy = (state_reg != IDLE);
  assign done = (state_reg != IDLE) && (count_reg == CW'(1));

  always_comb begin
    result = neg_reg ? -prod : prod;
    if (dbz_reg) begin
      result = {dvd_reg, 32'hFFFF_FFFF};
    end else if (state_reg == DIV) begin
      result[63:32] = rneg_reg ? -hi_c[BITS_PER_CYCLE] : hi_c[BITS_PER_CYCLE];
      result[31:0]  = neg_reg  ? -lo_c[BITS_PER_CYCLE] : lo_c[BITS_PER_CYCLE];
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    opnd_next  = opnd_reg;
    dvd_next   = dvd_reg;
    neg_next   = neg_reg;
    rneg_next  = rneg_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = is_div ? DIV : MUL;
          count_next = CW'(NUM_ITER);
          hi_next    = '0;
          lo_next    = is_div ? a_mag : b_mag;
          opnd_next  = is_div ? b_mag : a_mag;
          dvd_next   = op_a;
          neg_next   = is_signed & (op_a[31] ^ op_b[31]);
          rneg_next  = is_signed & op_a[31];
          dbz_next   = is_div & (op_b == 32'd0);
        end
      end
      MUL, DIV: begin
        hi_next    = hi_c[BITS_PER_CYCLE];
        lo_next    = lo_c[BITS_PER_CYCLE];
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= IDLE;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opnd_reg  <= '0;
      dvd_reg   <= '0;
      neg_reg   <= 1'b0;
      rneg_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      opnd_reg  <= opnd_next;
      dvd_reg   <= dvd_next;
      neg_reg   <= neg_next;
      rneg_reg  <= rneg_next;
      dbz_reg   <= dbz_next;
    end
  end

endmodule

// File: rtl/exe_muldiv_stage.sv
// EXE back end: EX/MEM pipeline register, HI/LO pair, mul/div issue and HI/LO hazard stall.
// BITS_PER_CYCLE must be 1, 2 or 4.
module exe_muldiv_stage
  import muldiv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [31:0] OperandA1_IN,
  input  logic [31:0] OperandB1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] ALU_result1_OUT,
  output logic [31:0] MemWriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic [5:0]  ALU_Control1_OUT,
  output logic        RegWrite1_OUT,
  output logic        MemRead1_OUT,
  output logic        MemWrite1_OUT,
  output logic        STALL_OUT,
  output logic        MulDivBusy_OUT
);

  ex_mem_t     ex_mem_reg, ex_mem_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        muldiv_in, is_mthi, is_mtlo, stall, start, busy, done;
  logic [63:0] md_result;

  assign muldiv_in = is_muldiv_op(ALU_Control1_IN);
  assign is_mthi   = (ALU_Control1_IN == OP_MTHI);
  assign is_mtlo   = (ALU_Control1_IN == OP_MTLO);
  assign stall     = busy & is_hilo_op(ALU_Control1_IN);
  assign start     = muldiv_in & ~busy;

  muldiv_iter #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_iter (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .is_div   (ALU_Control1_IN[1]),
    .is_signed(~ALU_Control1_IN[0]),
    .op_a     (OperandA1_IN),
    .op_b     (OperandB1_IN),
    .busy     (busy),
    .done     (done),
    .result   (md_result)
  );

  always_comb begin
    ex_mem_next = '0;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    if (!stall) begin
      ex_mem_next.instr      = Instr1_IN;
      ex_mem_next.pc         = Instr1_PC_IN;
      ex_mem_next.mem_wdata  = MemWriteData1_IN;
      ex_mem_next.write_reg  = WriteRegister1_IN;
      ex_mem_next.alu_ctrl   = ALU_Control1_IN;
      ex_mem_next.mem_read   = MemRead1_IN;
      ex_mem_next.mem_write  = MemWrite1_IN;
      ex_mem_next.reg_write  = RegWrite1_IN & ~(muldiv_in | is_mthi | is_mtlo);
      ex_mem_next.alu_result = (ALU_Control1_IN == OP_MFHI) ? hi_reg :
                               (ALU_Control1_IN == OP_MFLO) ? lo_reg : ALU_result1_IN;
      if (is_mthi) hi_next = OperandA1_IN;
      if (is_mtlo) lo_next = OperandA1_IN;
    end
    // MT* cannot coincide with completion: it stalls while the unit is busy.
    if (done) {hi_next, lo_next} = md_result;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ex_mem_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      ex_mem_reg <= ex_mem_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign Instr1_OUT         = ex_mem_reg.instr;
  assign Instr1_PC_OUT      = ex_mem_reg.pc;
  assign ALU_result1_OUT    = ex_mem_reg.alu_result;
  assign MemWriteData1_OUT  = ex_mem_reg.mem_wdata;
  assign WriteRegister1_OUT = ex_mem_reg.write_reg;
  assign ALU_Control1_OUT   = ex_mem_reg.alu_ctrl;
  assign RegWrite1_OUT      = ex_mem_reg.reg_write;
  assign MemRead1_OUT       = ex_mem_reg.mem_read;
  assign MemWrite1_OUT      = ex_mem_reg.mem_write;
  assign STALL_OUT          = stall;
  assign MulDivBusy_OUT     = busy;

endmodule
